// File: rtl/delay_line_ctrl.sv
// Delay-line sensor sequencer: discharge, launch, capture and average tap counts over 2^SAMPLES_LOG2
// samples. Define DLC_TAPS_SYNC_EN to add a two-flop synchronizer on the tap inputs.
module delay_line_ctrl #(
  parameter int unsigned TAPS         = 16,
  parameter int unsigned SETTLE       = 4,
  parameter int unsigned SAMPLES_LOG2 = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [TAPS-1:0]            i_taps,
  output logic                       o_launch,
  output logic                       o_arm,
  output logic                       o_busy,
  output logic                       o_valid,
  output logic [$clog2(TAPS+1)-1:0]  o_result,
  output logic                       o_err
);

  localparam int unsigned RW = $clog2(TAPS + 1);
  localparam int unsigned AW = RW + SAMPLES_LOG2;
  localparam int unsigned CW = $clog2(SETTLE + 3);
  localparam int unsigned SW = SAMPLES_LOG2 + 1;

  localparam logic [SW-1:0] LastSample = SW'((1 << SAMPLES_LOG2) - 1);
  localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);
`ifdef DLC_TAPS_SYNC_EN
  localparam logic [CW-1:0] CaptureLast = CW'(2);
`else
  localparam logic [CW-1:0] CaptureLast = CW'(0);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StDischarge,
    StLaunch,
    StCapture,
    StDone
  } state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [SW-1:0]   r_samp, w_samp_d;
  logic [AW-1:0]   r_acc, w_acc_d;
  logic            r_bub, w_bub_d;
  logic            r_launch, r_arm, r_busy, r_valid, r_err;
  logic [RW-1:0]   r_result;

  logic [TAPS-1:0] w_snap;
  logic [TAPS-1:0] w_snap_inc;
  logic [RW-1:0]   w_pop;
  logic            w_bubble;

`ifdef DLC_TAPS_SYNC_EN
  logic [TAPS-1:0] r_sync1, r_sync2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_taps;
      r_sync2 <= r_sync1;
    end
  end

  assign w_snap = r_sync2;
`else
  // Chain is synchronous to i_clk by construction; sample it directly.
  assign w_snap = i_taps;
`endif

  function automatic logic [RW-1:0] popcount(input logic [TAPS-1:0] v);
    logic [RW-1:0] sum;
    sum = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      sum = sum + RW'(v[i]);
    end
    return sum;
  endfunction

  // A clean thermometer code 0..01..1 has no bit set in common with itself plus one.
  assign w_snap_inc = w_snap + TAPS'(1);
  assign w_bubble   = |(w_snap & w_snap_inc);
  assign w_pop      = popcount(w_snap);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_samp_d  = r_samp;
    w_acc_d   = r_acc;
    w_bub_d   = r_bub;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StDischarge;
          w_cnt_d   = '0;
          w_samp_d  = '0;
          w_acc_d   = '0;
          w_bub_d   = 1'b0;
        end
      end
      StDischarge: begin
        if (r_cnt == SettleLast) begin
          w_state_d = StLaunch;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StLaunch: begin
        if (r_cnt == SettleLast) begin
          w_state_d = StCapture;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StCapture: begin
        if (r_cnt == CaptureLast) begin
          w_cnt_d = '0;
          w_acc_d = r_acc + AW'(w_pop);
          w_bub_d = r_bub | w_bubble;
          if (r_samp == LastSample) begin
            w_state_d = StDone;
          end else begin
            w_state_d = StDischarge;
            w_samp_d  = r_samp + SW'(1);
          end
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_samp   <= '0;
      r_acc    <= '0;
      r_bub    <= 1'b0;
      r_launch <= 1'b0;
      r_arm    <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_samp   <= w_samp_d;
      r_acc    <= w_acc_d;
      r_bub    <= w_bub_d;
      r_launch <= (w_state_d == StLaunch) || (w_state_d == StCapture);
      r_arm    <= (w_state_d == StLaunch) || (w_state_d == StCapture);
      r_busy   <= (w_state_d == StDischarge) || (w_state_d == StLaunch) ||
                  (w_state_d == StCapture);
      r_valid  <= (w_state_d == StDone);
      if (w_state_d == StDone) begin
        r_result <= RW'(w_acc_d >> SAMPLES_LOG2);
        r_err    <= w_bub_d;
      end
    end
  end

  assign o_launch = r_launch;
  assign o_arm    = r_arm;
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_err    = r_err;

endmodule
